// File: rtl/bdc_pkg.sv
// Shared constants and types for the BDCDrv command path: frame header,
// command codes for downstream consumers, and the parser state encoding.
package bdc_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  // Command codes consumed by the motor control logic (not validated by the parser)
  localparam logic [7:0] CMD_SET_DUTY = 8'h01;
  localparam logic [7:0] CMD_SET_DIR  = 8'h02;
  localparam logic [7:0] CMD_STOP     = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_AHI  = 3'd2,
    S_ALO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

endpackage

// File: rtl/byte_strobe_sync.sv
// Brings an asynchronous level flag into the clk domain via a 2-flop
// synchronizer and emits a registered one-cycle strobe per rising edge.
module byte_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic stb_out
);

  logic sync1;
  logic sync2;
  logic sync_prev;

  // Synchronize the flag, remember its previous value, register the rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      stb_out   <= 1'b0;
    end else begin
      sync1     <= async_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      stb_out   <= sync2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (HEADER, CMD, ARG_HI, ARG_LO, CHK) from
// uart_rx bytes, verifies the 8-bit additive checksum and enforces an
// inter-byte timeout. Optional macro UART_CMD_PARSER_STATS_EN adds
// saturating good/bad frame counters.
module uart_cmd_parser
  import bdc_pkg::*;
#(
  parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic        frame_err,
  output logic        busy
`ifdef UART_CMD_PARSER_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  // Error fires on the edge where the counter would reach TIMEOUT_CYCLES-1,
  // i.e. TIMEOUT_CYCLES-1 clocks after the last accepted byte.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 2);

  logic             byte_stb;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       work_cmd, work_cmd_n;
  logic [7:0]       work_hi, work_hi_n;
  logic [7:0]       work_lo, work_lo_n;
  logic [7:0]       sum, sum_n;
  logic             valid_n, err_n;
  logic [7:0]       code_n;
  logic [15:0]      arg_n;

  byte_strobe_sync u_stb (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx_done),
    .stb_out  (byte_stb)
  );

  assign busy = (state != S_IDLE);

  // State, timeout counter, working frame registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      work_cmd  <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      sum       <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      work_cmd  <= work_cmd_n;
      work_hi   <= work_hi_n;
      work_lo   <= work_lo_n;
      sum       <= sum_n;
      cmd_valid <= valid_n;
      frame_err <= err_n;
      cmd_code  <= code_n;
      cmd_arg   <= arg_n;
    end
  end

  // Next-state: byte-driven frame walk, timeout abort, checksum verdict
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    work_cmd_n = work_cmd;
    work_hi_n  = work_hi;
    work_lo_n  = work_lo;
    sum_n      = sum;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    code_n     = cmd_code;
    arg_n      = cmd_arg;

    // A byte arriving on the terminal-count cycle takes priority over the timeout
    if (state == S_IDLE || byte_stb) begin
      cnt_n = '0;
    end else if (cnt == TERM_CNT) begin
      cnt_n   = '0;
      err_n   = 1'b1;
      state_n = S_IDLE;
    end else begin
      cnt_n = cnt + 1'b1;
    end

    if (byte_stb) begin
      case (state)
        S_IDLE: if (rx_data == HEADER) state_n = S_CMD;
        S_CMD: begin
          work_cmd_n = rx_data;
          sum_n      = rx_data;
          state_n    = S_AHI;
        end
        S_AHI: begin
          work_hi_n = rx_data;
          sum_n     = sum + rx_data;
          state_n   = S_ALO;
        end
        S_ALO: begin
          work_lo_n = rx_data;
          sum_n     = sum + rx_data;
          state_n   = S_CHK;
        end
        S_CHK: begin
          if (rx_data == sum) begin
            valid_n = 1'b1;
            code_n  = work_cmd;
            arg_n   = {work_hi, work_lo};
          end else begin
            err_n = 1'b1;
          end
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

`ifdef UART_CMD_PARSER_STATS_EN
  // Saturating counts of good and bad frame pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (cmd_valid && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (frame_err && bad_cnt != '1)  bad_cnt  <= bad_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a frame-level reference model
// (byte queue, sum, elapsed-cycle timeout) compared every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_uart_cmd_parser;

  localparam logic [7:0]  HDR = 8'hAA;
  localparam int unsigned T   = 300;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int unsigned at;
    logic [7:0]  d;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        cmd_valid, frame_err, busy;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
`ifdef UART_CMD_PARSER_STATS_EN
  logic [15:0] good_cnt, bad_cnt;
`endif

  uart_cmd_parser #(
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_arg   (cmd_arg),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_CMD_PARSER_STATS_EN
    ,
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model ----------------
  ev_t         pend[$];
  logic [7:0]  fb[$];
  logic        m_prev = 1'b0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  logic [7:0]  m_code = '0;
  logic [15:0] m_arg = '0;
  logic [15:0] m_good = '0, m_bad = '0;
  int unsigned edge_n = 0, last_at = 0;

  task automatic model_step();
    logic [7:0] b, s;
    bit got;
    if (reset) begin
      pend.delete();
      fb.delete();
      m_prev = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_code = '0; m_arg = '0; m_good = '0; m_bad = '0;
      edge_n = 0; last_at = 0;
      return;
    end
    edge_n++;
    if (m_valid && m_good != 16'hFFFF) m_good++;
    if (m_err && m_bad != 16'hFFFF) m_bad++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    // A byte becomes visible to the frame logic 3 edges after rx_done is first seen high
    if (rx_done && !m_prev) pend.push_back('{at: edge_n + 3, d: rx_data});
    m_prev = rx_done;
    got = (pend.size() > 0) && (pend[0].at == edge_n);
    if (got) begin
      b = pend[0].d;
      void'(pend.pop_front());
      if (fb.size() == 0) begin
        if (b == HDR) fb.push_back(b);
      end else begin
        fb.push_back(b);
      end
      if (fb.size() == 5) begin
        s = fb[1] + fb[2] + fb[3];
        if (fb[4] == s) begin
          m_valid = 1'b1;
          m_code  = fb[1];
          m_arg   = {fb[2], fb[3]};
        end else begin
          m_err = 1'b1;
        end
        fb.delete();
      end
      last_at = edge_n;
    end else if (fb.size() > 0 && (edge_n - last_at) == T - 1) begin
      m_err = 1'b1;
      fb.delete();
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // ---------------- compare + pulse monitor ----------------
  int unsigned vp = 0, ep = 0, valid_cyc = 0, err_cyc = 0;

  initial forever begin
    @(negedge clk);
    check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    check("busy", {31'd0, busy}, {31'd0, (fb.size() > 0)});
    check("cmd_code", {24'd0, cmd_code}, {24'd0, m_code});
    check("cmd_arg", {16'd0, cmd_arg}, {16'd0, m_arg});
`ifdef UART_CMD_PARSER_STATS_EN
    check("good_cnt", {16'd0, good_cnt}, {16'd0, m_good});
    check("bad_cnt", {16'd0, bad_cnt}, {16'd0, m_bad});
`endif
    if (cmd_valid) begin vp++; valid_cyc = cyc; end
    if (frame_err) begin ep++; err_cyc = cyc; end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned last_c0 = 0;

  task automatic send_byte(input logic [7:0] b, input int unsigned hold, input int unsigned gap);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    last_c0 = cyc;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_seq(input bytes_t bs, input int unsigned hold, input int unsigned gap);
    foreach (bs[i]) send_byte(bs[i], hold, gap);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    vp = 0; ep = 0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int unsigned c01;
    bytes_t      q;
    logic [7:0]  cmd, hi, lo;
    int unsigned kind, n;

    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_code", {24'd0, cmd_code}, 32'd0);
    check("rst_cmd_arg", {16'd0, cmd_arg}, 32'd0);
    reset = 1'b0;
    idle(4);

    // Good frame and its latency
    clr();
    send_seq('{8'hAA, 8'h01, 8'h12, 8'h34, 8'h47}, 2, 5);
    idle(10);
    check("t1_latency", valid_cyc - last_c0, 32'd4);
    check("t1_valid_pulses", vp, 32'd1);
    check("t1_err_pulses", ep, 32'd0);
    check("t1_code", {24'd0, cmd_code}, 32'h01);
    check("t1_arg", {16'd0, cmd_arg}, 32'h1234);

    // Bad checksum keeps previous command
    clr();
    send_seq('{8'hAA, 8'h01, 8'h12, 8'h34, 8'h48}, 2, 5);
    idle(10);
    check("t2_err_pulses", ep, 32'd1);
    check("t2_valid_pulses", vp, 32'd0);
    check("t2_code", {24'd0, cmd_code}, 32'h01);
    check("t2_arg", {16'd0, cmd_arg}, 32'h1234);

    // Leading garbage ignored
    clr();
    send_seq('{8'h13, 8'h55, 8'hAA, 8'h02, 8'h00, 8'h01, 8'h03}, 3, 6);
    idle(10);
    check("t3_err_pulses", ep, 32'd0);
    check("t3_valid_pulses", vp, 32'd1);
    check("t3_code", {24'd0, cmd_code}, 32'h02);
    check("t3_arg", {16'd0, cmd_arg}, 32'h0001);

    // Inter-byte timeout, then recovery
    clr();
    send_byte(8'hAA, 2, 5);
    send_byte(8'h01, 2, 5);
    c01 = last_c0;
    idle(T + 20);
    check("t4_err_pulses", ep, 32'd1);
    check("t4_err_timing", err_cyc - c01, T + 3);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_valid_pulses", vp, 32'd0);
    clr();
    send_seq('{8'hAA, 8'h03, 8'hFF, 8'hFF, 8'h01}, 2, 5);
    idle(10);
    check("t4b_valid_pulses", vp, 32'd1);
    check("t4b_code", {24'd0, cmd_code}, 32'h03);
    check("t4b_arg", {16'd0, cmd_arg}, 32'hFFFF);

    // Long rx_done levels give one byte each
    clr();
    send_seq('{8'hAA, 8'h01, 8'h00, 8'h00, 8'h01}, 200, 5);
    idle(10);
    check("t5_valid_pulses", vp, 32'd1);
    check("t5_err_pulses", ep, 32'd0);

    // Asynchronous reset mid-frame
    send_seq('{8'hAA, 8'h01, 8'h12}, 2, 5);
    idle(5);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_code", {24'd0, cmd_code}, 32'd0);
    check("t6_rst_arg", {16'd0, cmd_arg}, 32'd0);
    check("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("t6_rst_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    clr();
    send_seq('{8'h34, 8'h47, 8'hAA, 8'h01, 8'h00, 8'h05, 8'h06}, 2, 5);
    idle(10);
    check("t6_valid_pulses", vp, 32'd1);
    check("t6_err_pulses", ep, 32'd0);
    check("t6_code", {24'd0, cmd_code}, 32'h01);
    check("t6_arg", {16'd0, cmd_arg}, 32'h0005);
`ifdef UART_CMD_PARSER_STATS_EN
    check("t6_good_cnt", {16'd0, good_cnt}, 32'd1);
    check("t6_bad_cnt", {16'd0, bad_cnt}, 32'd0);
`endif

    // Randomized traffic checked cycle by cycle against the model
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      cmd  = 8'($urandom);
      hi   = 8'($urandom);
      lo   = 8'($urandom);
      q.delete();
      if (kind == 2) q.push_back(8'($urandom_range(0, 8'hA9)));
      q.push_back(HDR);
      q.push_back(cmd);
      q.push_back(hi);
      q.push_back(lo);
      q.push_back(8'(cmd + hi + lo) ^ ((kind == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00));
      if (kind == 3) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < int'(n); i++) send_byte(q[i], $urandom_range(1, 8), $urandom_range(4, 40));
        idle(T + 20);
      end else begin
        foreach (q[i]) send_byte(q[i], $urandom_range(1, 8), $urandom_range(4, 40));
      end
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
